// File: rtl/display_pkg.sv
// Shared definitions for the display path: default field widths and the
// arbiter state encoding.
package display_pkg;

  localparam int SEG_W_DEF = 32;
  localparam int LED_W_DEF = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/display_arbiter_if.sv
// Producer-side bus of the display arbiter: per-source requests and data,
// plus the grant returned to the producers.
interface display_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int SEG_W   = 32,
  parameter int LED_W   = 16
);
  localparam int IW = $clog2(NUM_SRC);

  // Handshake: req[i] is a level; a source is shown while gnt[i] is high.
  // gnt is one-hot (or zero when idle) and only changes on frame ticks,
  // so a source may drop req at any time and simply loses the slot at the
  // next tick.
  logic [NUM_SRC-1:0]       req;
  logic [NUM_SRC*SEG_W-1:0] src_segments;
  logic [NUM_SRC*LED_W-1:0] src_red;
  logic [NUM_SRC*LED_W-1:0] src_green;
  logic [NUM_SRC-1:0]       gnt;
  logic [IW-1:0]            cur_src;

  modport master (
    output req, src_segments, src_red, src_green,
    input  gnt, cur_src
  );

  modport slave (
    input  req, src_segments, src_red, src_green,
    output gnt, cur_src
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward,
// with wrap, from start+1; start itself is the last candidate unless excluded.
module rr_pick #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] start,
  input  logic                       excl_start,
  output logic                       found,
  output logic [$clog2(NUM_SRC)-1:0] idx
);
  localparam int IW = $clog2(NUM_SRC);

  int            cand;
  logic [IW-1:0] cand_idx;

  // Walk offsets from far to near so the nearest requester wins.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand = int'(start) + k;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      cand_idx = IW'(cand);
      if (req[cand_idx] && !(excl_start && k == NUM_SRC)) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Frame-synchronous round-robin arbiter feeding the display LEDs and
// seven-segment digits; ownership and shown data change only on vsync ticks.
module display_arbiter
  import display_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_FRAMES = 60,
  parameter int SEG_W        = SEG_W_DEF,
  parameter int LED_W        = LED_W_DEF,
  parameter bit VSYNC_POL    = 1'b0
) (
  input  logic               clk_video,
  input  logic               reset_n,
  input  logic               vsync,
  input  logic               hold,
  display_arbiter_if.slave   src_bus,
  output logic [SEG_W-1:0]   segments,
  output logic [LED_W-1:0]   red_leds,
  output logic [LED_W-1:0]   green_leds,
  output logic               frame_tick,
  output arb_state_t         state_dbg
);
  localparam int IW = $clog2(NUM_SRC);
  localparam int DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_FRAMES - 1);
  localparam logic [IW-1:0] LAST_RST  = IW'(NUM_SRC - 1);

  arb_state_t         state;
  logic               vsync_q;
  logic               tick;
  logic [IW-1:0]      owner;
  logic [IW-1:0]      last;
  logic [DW-1:0]      dwell;
  logic [NUM_SRC-1:0] gnt_q;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          take;
  logic          drop;
  logic [IW-1:0] show_idx;
  logic [SEG_W-1:0] sel_seg;
  logic [LED_W-1:0] sel_red;
  logic [LED_W-1:0] sel_green;

  assign tick = (vsync == VSYNC_POL) && (vsync_q != VSYNC_POL);

  // In GRANT, last always equals the owner, so one picker serves both the
  // idle search (owner included) and rotation (owner excluded).
  rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req        (src_bus.req),
    .start      (last),
    .excl_start (state == ST_GRANT),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  always_comb begin
    take = 1'b0;
    drop = 1'b0;
    if (state == ST_IDLE) begin
      take = pick_found;
    end else if (!src_bus.req[owner]) begin
      take = pick_found;
      drop = !pick_found;
    end else if (!hold && dwell == DWELL_MAX && pick_found) begin
      take = 1'b1;
    end
    show_idx = take ? pick_idx : owner;
  end

  always_comb begin
    sel_seg   = '0;
    sel_red   = '0;
    sel_green = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (show_idx == IW'(i)) begin
        sel_seg   = src_bus.src_segments[i*SEG_W +: SEG_W];
        sel_red   = src_bus.src_red[i*LED_W +: LED_W];
        sel_green = src_bus.src_green[i*LED_W +: LED_W];
      end
    end
  end

  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q    <= ~VSYNC_POL;
      frame_tick <= 1'b0;
      state      <= ST_IDLE;
      owner      <= '0;
      last       <= LAST_RST;
      dwell      <= '0;
      gnt_q      <= '0;
      segments   <= '0;
      red_leds   <= '0;
      green_leds <= '0;
    end else begin
      vsync_q    <= vsync;
      frame_tick <= tick;
      if (tick) begin
        if (take) begin
          state      <= ST_GRANT;
          owner      <= pick_idx;
          last       <= pick_idx;
          dwell      <= '0;
          gnt_q      <= {{(NUM_SRC-1){1'b0}}, 1'b1} << pick_idx;
          segments   <= sel_seg;
          red_leds   <= sel_red;
          green_leds <= sel_green;
        end else if (drop) begin
          state      <= ST_IDLE;
          owner      <= '0;
          dwell      <= '0;
          gnt_q      <= '0;
          segments   <= '0;
          red_leds   <= '0;
          green_leds <= '0;
        end else if (state == ST_GRANT) begin
          if (dwell != DWELL_MAX) dwell <= dwell + 1'b1;
          segments   <= sel_seg;
          red_leds   <= sel_red;
          green_leds <= sel_green;
        end
      end
    end
  end

  assign src_bus.gnt     = gnt_q;
  assign src_bus.cur_src = owner;
  assign state_dbg       = state;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed and randomized frame-level checks of display_arbiter against a
// behavioural round-robin model.
module tb_display_arbiter;
  import display_pkg::*;

  localparam int N  = 4;
  localparam int D  = 3;
  localparam int SW = 32;
  localparam int LW = 16;

  // clock / reset
  logic clk_video = 1'b0;
  logic reset_n   = 1'b0;
  logic vsync     = 1'b1;
  logic hold      = 1'b0;
  logic [SW-1:0] segments;
  logic [LW-1:0] red_leds;
  logic [LW-1:0] green_leds;
  logic          frame_tick;
  arb_state_t    state_dbg;

  always #5 clk_video = ~clk_video;

  display_arbiter_if #(.NUM_SRC(N), .SEG_W(SW), .LED_W(LW)) bus ();

  display_arbiter #(
    .NUM_SRC(N), .DWELL_FRAMES(D), .SEG_W(SW), .LED_W(LW), .VSYNC_POL(1'b0)
  ) dut (
    .clk_video  (clk_video),
    .reset_n    (reset_n),
    .vsync      (vsync),
    .hold       (hold),
    .src_bus    (bus.slave),
    .segments   (segments),
    .red_leds   (red_leds),
    .green_leds (green_leds),
    .frame_tick (frame_tick),
    .state_dbg  (state_dbg)
  );

  // stimulus state
  logic [N-1:0]  req_v;
  logic [SW-1:0] seg_d   [N];
  logic [LW-1:0] red_d   [N];
  logic [LW-1:0] green_d [N];

  // reference model
  int            m_owner;
  int            m_last;
  int            m_dwell;
  logic [SW-1:0] m_seg;
  logic [LW-1:0] m_red;
  logic [LW-1:0] m_green;

  // scoreboard
  logic [SW-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    bus.req = req_v;
    for (int i = 0; i < N; i++) begin
      bus.src_segments[i*SW +: SW] = seg_d[i];
      bus.src_red[i*LW +: LW]      = red_d[i];
      bus.src_green[i*LW +: LW]    = green_d[i];
    end
  endtask

  task automatic randomize_data();
    for (int i = 0; i < N; i++) begin
      seg_d[i]   = $urandom;
      red_d[i]   = 16'($urandom);
      green_d[i] = 16'($urandom);
    end
  endtask

  function automatic bit req_bit(input int i);
    logic [N-1:0] sh;
    sh = req_v >> i;
    return sh[0];
  endfunction

  // First requester at positions start+1 .. start+span (mod N), or -1.
  function automatic int next_after(input int start, input int span);
    for (int k = 1; k <= span; k++) begin
      if (req_bit((start + k) % N)) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_dwell = 0;
    m_seg   = '0;
    m_red   = '0;
    m_green = '0;
    exp_q.delete();
  endtask

  task automatic show(input int n);
    m_seg   = seg_d[n];
    m_red   = red_d[n];
    m_green = green_d[n];
  endtask

  task automatic grant(input int n);
    m_owner = n;
    m_last  = n;
    m_dwell = 0;
    show(n);
  endtask

  task automatic model_tick();
    int n;
    if (m_owner < 0) begin
      n = next_after(m_last, N);
      if (n >= 0) grant(n);
    end else if (!req_bit(m_owner)) begin
      n = next_after(m_owner, N - 1);
      if (n >= 0) grant(n);
      else begin
        m_owner = -1;
        m_dwell = 0;
        m_seg   = '0;
        m_red   = '0;
        m_green = '0;
      end
    end else begin
      n = next_after(m_owner, N - 1);
      if (!hold && m_dwell == D - 1 && n >= 0) grant(n);
      else begin
        if (m_dwell < D - 1) m_dwell++;
        show(m_owner);
      end
    end
    exp_q.push_back(m_seg);
  endtask

  task automatic check_outputs(input string tag);
    logic [63:0] exp_gnt;
    exp_gnt = (m_owner < 0) ? 64'd0 : (64'd1 << m_owner);
    check({tag, ".gnt"}, bus.gnt, exp_gnt);
    check({tag, ".cur_src"}, bus.cur_src, (m_owner < 0) ? 64'd0 : 64'(m_owner));
    check({tag, ".red"}, red_leds, m_red);
    check({tag, ".green"}, green_leds, m_green);
    check({tag, ".state"}, state_dbg, (m_owner < 0) ? ST_IDLE : ST_GRANT);
  endtask

  // driver: one frame with a 2-cycle active vsync and 3 inactive cycles
  task automatic frame(input string tag);
    vsync = 1'b0;
    @(posedge clk_video);
    model_tick();
    @(negedge clk_video);
    check({tag, ".frame_tick"}, frame_tick, 1'b1);
    check({tag, ".segments"}, segments, exp_q.pop_front());
    check_outputs(tag);
    @(posedge clk_video);
    @(negedge clk_video);
    check({tag, ".tick_width"}, frame_tick, 1'b0);
    vsync = 1'b1;
    repeat (3) @(negedge clk_video);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    model_reset();
    check({tag, ".seg_rst"}, segments, 0);
    check({tag, ".tick_rst"}, frame_tick, 1'b0);
    check_outputs(tag);
    @(negedge clk_video);
    reset_n = 1'b1;
    @(negedge clk_video);
  endtask

  initial begin
    int seq[7] = '{0, 0, 0, 2, 2, 2, 0};
    randomize_data();
    req_v = '0;
    apply();
    @(negedge clk_video);
    do_reset("reset");

    // single requester: outputs zero until the tick, then src0
    req_v = 4'b0001;
    apply();
    repeat (2) @(negedge clk_video);
    check("pre_tick.seg", segments, 0);
    check_outputs("pre_tick");
    frame("first");
    check("first.gnt_dir", bus.gnt, 4'b0001);
    check("first.seg_dir", segments, seg_d[0]);

    // two requesters, dwell of 3 frames each
    do_reset("dwell_rst");
    req_v = 4'b0101;
    apply();
    for (int i = 0; i < 7; i++) begin
      frame("dwell");
      check("dwell.seq", bus.cur_src, seq[i]);
    end

    // owner drops mid-dwell: wrap to src0, dwell restarts
    do_reset("drop_rst");
    req_v = 4'b0100;
    apply();
    frame("drop_a");
    frame("drop_b");
    req_v = 4'b0011;
    apply();
    frame("drop_c");
    check("drop.wrap", bus.cur_src, 0);
    frame("drop_d");
    frame("drop_e");
    check("drop.dwell_kept", bus.cur_src, 0);
    frame("drop_f");
    check("drop.dwell_rot", bus.cur_src, 1);

    // hold freezes rotation; release rotates to src1
    do_reset("hold_rst");
    req_v = 4'b1111;
    hold  = 1'b1;
    apply();
    for (int i = 0; i < 10; i++) begin
      frame("hold");
      check("hold.owner", bus.cur_src, 0);
    end
    hold = 1'b0;
    frame("hold_rel");
    check("hold_rel.owner", bus.cur_src, 1);

    // data change mid-frame invisible until the next tick
    seg_d[1] = $urandom;
    red_d[1] = 16'($urandom);
    apply();
    repeat (2) @(negedge clk_video);
    check("midframe.seg", segments, m_seg);
    check_outputs("midframe");
    frame("newdata");
    check("newdata.seg", segments, seg_d[1]);

    // all requests gone: idle with zeroed outputs
    req_v = 4'b0000;
    apply();
    frame("idle");
    check("idle.seg", segments, 0);
    check("idle.gnt", bus.gnt, 0);

    // reset mid-frame while src1 owns: first grant afterwards is src0
    do_reset("mid_rst_a");
    req_v = 4'b0010;
    apply();
    frame("pre_mid");
    req_v = 4'b0111;
    apply();
    @(negedge clk_video);
    do_reset("mid_rst");
    frame("post_mid");
    check("post_mid.owner", bus.cur_src, 0);

    // randomized frames
    do_reset("rand_rst");
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 2) == 0) req_v = 4'($urandom_range(0, 15));
      hold = ($urandom_range(0, 3) == 0);
      randomize_data();
      apply();
      frame("rand");
      randomize_data();
      apply();
      @(negedge clk_video);
      check("rand_mid.seg", segments, m_seg);
      check_outputs("rand_mid");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
# display_arbiter

Frame-synchronous time-slice arbiter that shares the `display` block's LED and seven-segment inputs (`red_leds`, `green_leds`, `segments`) among several requesting sources. It sits between the producers (counters, status logic, debug taps) and `display`, in the `clk_video` domain. It grants one source at a time in round-robin order, with a minimum dwell measured in video frames. Displayed values change only at frame boundaries, so the picture never tears.

## Interface
Parameters:
- `NUM_SRC`, default 4: number of requesting sources, 2..8.
- `DWELL_FRAMES`, default 60: minimum frames a granted source is shown before rotation when others are waiting, ≥1.
- `SEG_W`, default 32: segment field width (8 hex digits).
- `LED_W`, default 16: width of each LED field.
- `VSYNC_POL`, default 0: active level of `vsync`.

Ports:
- `clk_video` in 1: video pixel clock; everything is synchronous to it.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `vsync` in 1: vertical sync from `display`, same clock domain.
- `hold` in 1: when high, freezes rotation; the current owner stays granted past dwell.
- `req` in `NUM_SRC`: per-source request, level-sensitive.
- `src_segments` in `NUM_SRC*SEG_W`: packed segment data; source i occupies bits [i*SEG_W +: SEG_W].
- `src_red` in `NUM_SRC*LED_W`: packed red LED data.
- `src_green` in `NUM_SRC*LED_W`: packed green LED data.
- `gnt` out `NUM_SRC`: one-hot grant, or all-zero when idle.
- `cur_src` out `$clog2(NUM_SRC)`: index of the current owner; 0 when idle.
- `segments` out `SEG_W`: to `display.segments`.
- `red_leds` out `LED_W`: to `display.red_leds`.
- `green_leds` out `LED_W`: to `display.green_leds`.
- `frame_tick` out 1: one-cycle pulse per frame boundary.

## Operation
- Frame boundary:
  - `vsync` is registered once.
  - A tick is the cycle in which `vsync` first shows its active level (VSYNC_POL) while the registered copy does not.
  - All arbitration decisions and output updates happen only on ticks.
- States: IDLE (no owner) and GRANT (owner valid).
- IDLE:
  - At a tick with any `req` bit set → GRANT to the first requester searching upward, with wrap, from `last+1`.
  - Otherwise remain in IDLE.
- GRANT, at each tick, decided in priority order:
  1. Owner's `req` low → rotate to the next requester after the owner. If there is none → IDLE.
  2. `hold` low, and dwell == `DWELL_FRAMES-1`, and another `req` pending → rotate to the next requester after the owner.
  3. Otherwise keep the owner and increment dwell, saturating at `DWELL_FRAMES-1`.
- Dwell counter:
  - Cleared to 0 on every grant change, including IDLE→GRANT.
  - Width `$clog2(DWELL_FRAMES)`, minimum 1 bit.
- `last` register:
  - Updated to the owner index on every grant.
  - Reset value is `NUM_SRC-1`, so the first grant goes to source 0.
- Output data:
  - On every tick in GRANT, including when there is no owner change, `segments`/`red_leds`/`green_leds` latch the new owner's slice.
  - Between ticks the outputs are frozen; source data changes are invisible until the next tick.
  - On entering IDLE the outputs are zeroed.
- Simultaneous events:
  - Owner drops `req` on the same tick a new source raises it → rule 1 applies; the new source is eligible.
  - `hold` does not block rule 1.
- `DWELL_FRAMES`=1: with other requesters pending, rotation happens on every tick.

## Timing
- Tick detected at cycle T (first cycle with `vsync` active, as registered).
- `gnt`, `cur_src`, data outputs and `frame_tick` all update at T+1, from `req`/`hold`/source data sampled at T.
- `frame_tick` is high for exactly one cycle, T+1.
- Reset values: `gnt`=0, `cur_src`=0, `segments`=0, `red_leds`=0, `green_leds`=0, `frame_tick`=0, state IDLE, dwell=0, `last`=`NUM_SRC-1`, `vsync` register = inactive level.
- `reset_n` asserted mid-frame clears everything immediately. After release, the first tick is taken at the next vsync leading edge.
- Latency from `req` rising to the grant: 1..(frame period + 1) cycles when free. When another source is in its dwell, up to `DWELL_FRAMES` frames per source ahead in the rotation.

## Structure
- Shared package `display_pkg`:
  - `SEG_W`/`LED_W` defaults.
  - Arbiter state enum (IDLE, GRANT).
- Sub-module `rr_pick`:
  - Combinational round-robin picker.
  - Inputs: `req` vector, start index, exclude-owner flag.
  - Outputs: found flag and index.
- Top level: tick detector, state/dwell/`last` registers, output mux and latch.

## Test plan
- Reset, then `req`=0001, then vsync edge → `gnt`=0001 and `segments`=src0 data one cycle after the tick. All outputs were 0 before the tick.
- `req`=0101, `DWELL_FRAMES`=3 → grants go src0,src0,src0,src2,src2,src2,src0… on successive ticks. `frame_tick` pulses once per frame.
- Owner src2 drops `req` mid-dwell while `req`=0011 → next tick grants src0 (wrap after 2) and dwell resets to 0.
- `hold`=1 with `req`=1111 over 10 frames → src0 is kept for all 10. `hold` released → rotation to src1 at the next tick.
- Source data changed mid-frame → outputs unchanged until the next tick, then show the new value. All `req` low → IDLE, outputs 0 after the tick.
- `reset_n` pulsed low mid-frame while src1 is granted → outputs and `gnt` zero immediately. The first tick after release grants src0, not src2.
